// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg : shared NoC types, flit field positions and XY routing function
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package noc_pkg;

   typedef enum logic [2:0] {
      DIR_N    = 3'b000,
      DIR_S    = 3'b001,
      DIR_W    = 3'b010,
      DIR_E    = 3'b011,
      DIR_L    = 3'b100,
      DIR_NONE = 3'b111
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_REQ   = 2'd2,
      ST_SEND  = 2'd3
   } req_state_t;

   localparam int NUM_PORTS    = 5;
   // Widest coordinate the routing function accepts; callers zero-extend.
   localparam int COORD_MAX_W  = 8;
   // Destination fields sit in the low bits of the flit, field k at k*COORD_W.
   localparam int DEST_X_FIELD = 0;
   localparam int DEST_Y_FIELD = 1;

   // Dimension-ordered routing: resolve X fully before Y.
   function automatic dir_t xy_route(
      input logic [COORD_MAX_W-1:0] dest_x,
      input logic [COORD_MAX_W-1:0] dest_y,
      input logic [COORD_MAX_W-1:0] my_x,
      input logic [COORD_MAX_W-1:0] my_y
   );
      if (dest_x > my_x)      return DIR_E;
      else if (dest_x < my_x) return DIR_W;
      else if (dest_y > my_y) return DIR_N;
      else if (dest_y < my_y) return DIR_S;
      else                    return DIR_L;
   endfunction

endpackage

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
// ============================================================================
// noc_flit_fifo : power-of-two circular flit buffer with occupancy count
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module noc_flit_fifo #(
   parameter int FLIT_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [FLIT_W-1:0]          push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [FLIT_W-1:0]          head
);
   import noc_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/noc_input_port_requester.sv
// ============================================================================
// noc_input_port_requester : router input port - buffers flits, XY-routes the
// head, requests an output port and drives granted flits into the crossbar
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module noc_input_port_requester #(
   parameter int FLIT_W      = 32,
   parameter int COORD_W     = 2,
   parameter int DEPTH       = 4,
   parameter int MY_X        = 0,
   parameter int MY_Y        = 0,
   parameter int STALL_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] flit_i,
   input  logic              flit_valid_i,
   output logic              flit_ready_o,
   output logic [2:0]        nexthop_addr_o,
   input  logic [4:0]        grant_i,
   output logic [FLIT_W-1:0] flit_o,
   output logic              flit_valid_o,
   output logic              change_order_o,
   output logic              stall_o
);
   import noc_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(STALL_LIMIT + 1);

   req_state_t         state;
   dir_t               dir_q;
   dir_t               route_dir;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [AW:0]        fifo_count;
   logic [FLIT_W-1:0]  head;
   logic [COORD_W-1:0] dest_x;
   logic [COORD_W-1:0] dest_y;
   logic               granted;
   logic               more_after_pop;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   stall_inc;

   assign flit_ready_o = ~fifo_full;
   assign push         = flit_valid_i & flit_ready_o;
   assign pop          = (state == ST_SEND);

   noc_flit_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (flit_i),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head)
   );

   assign dest_x    = head[DEST_X_FIELD*COORD_W +: COORD_W];
   assign dest_y    = head[DEST_Y_FIELD*COORD_W +: COORD_W];
   assign route_dir = xy_route(COORD_MAX_W'(dest_x), COORD_MAX_W'(dest_y),
                               COORD_MAX_W'(MY_X),   COORD_MAX_W'(MY_Y));

   // Only the grant line of the requested output port matters.
   always_comb begin
      granted = 1'b0;
      case (dir_q)
         DIR_N:   granted = grant_i[0];
         DIR_S:   granted = grant_i[1];
         DIR_W:   granted = grant_i[2];
         DIR_E:   granted = grant_i[3];
         DIR_L:   granted = grant_i[4];
         default: granted = 1'b0;
      endcase
   end

   // A push landing in the SEND cycle also leaves a flit behind.
   assign more_after_pop = (fifo_count != (AW+1)'(1)) | push;
   assign stall_inc      = (stall_cnt == CNT_W'(STALL_LIMIT)) ? stall_cnt
                                                              : stall_cnt + CNT_W'(1);

   // stall_cnt holds the ordinal of the current REQ cycle, so stall_o is
   // registered yet rises in the STALL_LIMIT-th REQ cycle itself.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ST_IDLE;
         dir_q          <= DIR_NONE;
         nexthop_addr_o <= DIR_NONE;
         flit_o         <= '0;
         flit_valid_o   <= 1'b0;
         change_order_o <= 1'b0;
         stall_cnt      <= '0;
         stall_o        <= 1'b0;
      end else begin
         flit_valid_o   <= 1'b0;
         change_order_o <= 1'b0;
         stall_cnt      <= '0;
         stall_o        <= 1'b0;
         case (state)
            ST_IDLE: begin
               nexthop_addr_o <= DIR_NONE;
               if (!fifo_empty) state <= ST_ROUTE;
            end
            ST_ROUTE: begin
               dir_q          <= route_dir;
               nexthop_addr_o <= route_dir;
               stall_cnt      <= CNT_W'(1);
               stall_o        <= (CNT_W'(1) == CNT_W'(STALL_LIMIT));
               state          <= ST_REQ;
            end
            ST_REQ: begin
               if (granted) begin
                  flit_o         <= head;
                  flit_valid_o   <= 1'b1;
                  change_order_o <= 1'b1;
                  state          <= ST_SEND;
               end else begin
                  stall_cnt <= stall_inc;
                  stall_o   <= (stall_inc == CNT_W'(STALL_LIMIT));
               end
            end
            ST_SEND: begin
               nexthop_addr_o <= DIR_NONE;
               state          <= more_after_pop ? ST_ROUTE : ST_IDLE;
            end
            default: begin
               nexthop_addr_o <= DIR_NONE;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_noc_input_port_requester.sv
// ============================================================================
// tb_noc_input_port_requester : scoreboard bench for the router input port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_noc_input_port_requester;

   logic        clk;
   logic        reset;
   logic [31:0] flit_i;
   logic        flit_valid_i;
   logic        flit_ready_o;
   logic [2:0]  nexthop_addr_o;
   logic [4:0]  grant_i;
   logic [31:0] flit_o;
   logic        flit_valid_o;
   logic        change_order_o;
   logic        stall_o;

   int          vecs;
   int          errs;
   logic [31:0] sb[$];

   noc_input_port_requester #(
      .FLIT_W      (32),
      .COORD_W     (2),
      .DEPTH       (4),
      .MY_X        (1),
      .MY_Y        (1),
      .STALL_LIMIT (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flit_i         (flit_i),
      .flit_valid_i   (flit_valid_i),
      .flit_ready_o   (flit_ready_o),
      .nexthop_addr_o (nexthop_addr_o),
      .grant_i        (grant_i),
      .flit_o         (flit_o),
      .flit_valid_o   (flit_valid_o),
      .change_order_o (change_order_o),
      .stall_o        (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input int x, input int y, input int tag);
      return {28'(tag), 2'(y), 2'(x)};
   endfunction

   // Drive one flit for one edge; record it as expected only if it is accepted.
   task automatic push_flit(input logic [31:0] f);
      flit_i       = f;
      flit_valid_i = 1'b1;
      if (flit_ready_o) sb.push_back(f);
      tick();
      flit_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; flit_valid_i = 1'b0; flit_i = '0; grant_i = '0;
      tick(); tick();
      vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL reset_nexthop: got %b want 111", nexthop_addr_o); end
      vecs++; if (flit_valid_o !== 1'b0)     begin errs++; $display("FAIL reset_valid: got %b want 0", flit_valid_o); end
      vecs++; if (change_order_o !== 1'b0)   begin errs++; $display("FAIL reset_change: got %b want 0", change_order_o); end
      vecs++; if (stall_o !== 1'b0)          begin errs++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      vecs++; if (flit_ready_o !== 1'b1)     begin errs++; $display("FAIL reset_ready: got %b want 1", flit_ready_o); end
      vecs++; if (flit_o !== 32'h0)          begin errs++; $display("FAIL reset_flit: got %h want 0", flit_o); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic_east();
      logic [31:0] exp;
      grant_i = 5'b01000;
      push_flit(mk(2, 1, 'h11));
      vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL basic_c0_nexthop: got %b want 111", nexthop_addr_o); end
      tick();
      vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL basic_c1_nexthop: got %b want 111", nexthop_addr_o); end
      tick();
      vecs++; if (nexthop_addr_o !== 3'b011) begin errs++; $display("FAIL basic_c2_nexthop: got %b want 011", nexthop_addr_o); end
      vecs++; if (flit_valid_o !== 1'b0)     begin errs++; $display("FAIL basic_c2_valid: got %b want 0", flit_valid_o); end
      tick();
      vecs++; if (flit_valid_o !== 1'b1 || change_order_o !== 1'b1) begin
         errs++; $display("FAIL basic_c3_send: valid %b change %b want 1 1", flit_valid_o, change_order_o);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
      vecs++; if (flit_o !== exp) begin errs++; $display("FAIL basic_c3_flit: got %h want %h", flit_o, exp); end
      vecs++; if (nexthop_addr_o !== 3'b011) begin errs++; $display("FAIL basic_c3_nexthop: got %b want 011", nexthop_addr_o); end
      tick();
      vecs++; if (flit_valid_o !== 1'b0 || change_order_o !== 1'b0) begin
         errs++; $display("FAIL basic_c4_pulse: valid %b change %b want 0 0", flit_valid_o, change_order_o);
      end
      vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL basic_c4_nexthop: got %b want 111", nexthop_addr_o); end
      grant_i = '0;
      tick();
   endtask

   task automatic test_routes();
      int          xs[3]   = '{1, 1, 0};
      int          ys[3]   = '{1, 0, 3};
      logic [2:0]  want[3] = '{3'b100, 3'b001, 3'b010};
      logic [31:0] exp;
      for (int i = 0; i < 3; i++) begin
         grant_i = '0;
         push_flit(mk(xs[i], ys[i], 'h20 + i));
         tick(); tick();
         vecs++; if (nexthop_addr_o !== want[i]) begin errs++; $display("FAIL route_%0d_nexthop: got %b want %b", i, nexthop_addr_o, want[i]); end
         grant_i = 5'(1) << want[i];
         tick();
         vecs++; if (flit_valid_o !== 1'b1) begin errs++; $display("FAIL route_%0d_valid: got %b want 1", i, flit_valid_o); end
         exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
         vecs++; if (flit_o !== exp) begin errs++; $display("FAIL route_%0d_flit: got %h want %h", i, flit_o, exp); end
         grant_i = '0;
         tick();
         vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL route_%0d_idle: got %b want 111", i, nexthop_addr_o); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      int          nsend;
      int          last;
      int          first;
      grant_i = '0;
      push_flit(mk(2, 1, 'h31));
      push_flit(mk(1, 2, 'h32));
      push_flit(mk(3, 0, 'h33));
      push_flit(mk(1, 3, 'h34));
      vecs++; if (flit_ready_o !== 1'b0) begin errs++; $display("FAIL fill_ready_full: got %b want 0", flit_ready_o); end
      push_flit(mk(2, 2, 'h99));
      vecs++; if (flit_ready_o !== 1'b0) begin errs++; $display("FAIL fill_ready_after5: got %b want 0", flit_ready_o); end
      grant_i = 5'b01001;
      nsend = 0; last = -10; first = -10;
      for (int cyc = 0; cyc < 40; cyc++) begin
         tick();
         if (cyc == first + 1) begin
            vecs++; if (flit_ready_o !== 1'b1) begin errs++; $display("FAIL fill_ready_after_pop: got %b want 1", flit_ready_o); end
         end
         if (flit_valid_o === 1'b1) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
            vecs++; if (flit_o !== exp) begin errs++; $display("FAIL fill_order_%0d: got %h want %h", nsend, flit_o, exp); end
            if (nsend == 0) begin
               first = cyc;
               vecs++; if (flit_ready_o !== 1'b0) begin errs++; $display("FAIL fill_ready_in_send: got %b want 0", flit_ready_o); end
            end else begin
               vecs++; if (cyc - last !== 3) begin errs++; $display("FAIL fill_cadence_%0d: got %0d cycles want 3", nsend, cyc - last); end
            end
            last = cyc;
            nsend++;
         end
         if (nsend == 4 && cyc > last + 2) break;
      end
      vecs++; if (nsend !== 4) begin errs++; $display("FAIL fill_count: got %0d sends want 4", nsend); end
      grant_i = '0;
      sb.delete();
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] exp;
      grant_i = 5'b00001;
      push_flit(mk(2, 1, 'h41));
      tick(); tick();
      for (int k = 1; k <= 20; k++) begin
         vecs++; if (flit_valid_o !== 1'b0) begin errs++; $display("FAIL stall_no_send_%0d: got %b want 0", k, flit_valid_o); end
         vecs++; if (stall_o !== (k >= 16)) begin errs++; $display("FAIL stall_req%0d: got %b want %b", k, stall_o, (k >= 16)); end
         if (k < 20) tick();
      end
      grant_i = 5'b01000;
      tick();
      vecs++; if (flit_valid_o !== 1'b1) begin errs++; $display("FAIL stall_send: got %b want 1", flit_valid_o); end
      vecs++; if (stall_o !== 1'b0)      begin errs++; $display("FAIL stall_clear: got %b want 0", stall_o); end
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
      vecs++; if (flit_o !== exp) begin errs++; $display("FAIL stall_flit: got %h want %h", flit_o, exp); end
      grant_i = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      grant_i = '0;
      push_flit(mk(2, 1, 'h51));
      push_flit(mk(0, 1, 'h52));
      push_flit(mk(1, 2, 'h53));
      vecs++; if (nexthop_addr_o !== 3'b011) begin errs++; $display("FAIL rst_mid_req: got %b want 011", nexthop_addr_o); end
      reset   = 1'b0;
      grant_i = 5'b11111;
      tick();
      vecs++; if (nexthop_addr_o !== 3'b111) begin errs++; $display("FAIL rst_mid_nexthop: got %b want 111", nexthop_addr_o); end
      vecs++; if (flit_valid_o !== 1'b0)     begin errs++; $display("FAIL rst_mid_valid: got %b want 0", flit_valid_o); end
      vecs++; if (flit_ready_o !== 1'b1)     begin errs++; $display("FAIL rst_mid_ready: got %b want 1", flit_ready_o); end
      vecs++; if (change_order_o !== 1'b0)   begin errs++; $display("FAIL rst_mid_change: got %b want 0", change_order_o); end
      reset = 1'b1;
      sb.delete();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (flit_valid_o !== 1'b0) bad++;
      end
      vecs++; if (bad !== 0) begin errs++; $display("FAIL rst_mid_no_send: got %0d send cycles want 0", bad); end
      grant_i = '0;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_basic_east();
      test_routes();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire
